debug_ctrl: RTL and testbench

DEBUG_CTRL -- requirements
Module: debug_ctrl

---
 rtl/debug_pkg.sv | 21 ++
 rtl/debug_word_ser.sv | 52 +++++
 rtl/debug_ctrl.sv | 166 ++++++++++++++++
 tb/tb_debug_ctrl.sv | 337 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/debug_pkg.sv
// Shared command codes and controller state encoding for the UART debug controller.
package debug_pkg;

  localparam logic [7:0] CMD_LOAD  = 8'h01;
  localparam logic [7:0] CMD_RUN   = 8'h02;
  localparam logic [7:0] CMD_STEP  = 8'h03;
  localparam logic [7:0] CMD_DUMP  = 8'h04;
  localparam logic [7:0] CMD_ABORT = 8'h05;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_LOAD_RX   = 3'd1;
  localparam state_t ST_LOAD_WR   = 3'd2;
  localparam state_t ST_RUN       = 3'd3;
  localparam state_t ST_STEP      = 3'd4;
  localparam state_t ST_DUMP_LD   = 3'd5;
  localparam state_t ST_DUMP_TX   = 3'd6;
  localparam state_t ST_DUMP_WAIT = 3'd7;

endpackage

// File: rtl/debug_word_ser.sv
// Holds one latched debug word and presents it to the UART one byte at a time,
// least-significant byte first.
module debug_word_ser
  import debug_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              load,
  input  logic [DATA_W-1:0] word_in,
  input  logic              send,
  input  logic              shift,
  output logic              tx_start,
  output logic [7:0]        tx_data,
  output logic              last_byte
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BYTES - 1);

  logic [DATA_W-1:0] word_q, word_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (load) begin
      word_d = word_in;
      cnt_d  = '0;
    end else if (shift) begin
      word_d = word_q >> 8;
      cnt_d  = (cnt_q == LAST_CNT) ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign tx_start  = send;
  assign tx_data   = word_q[7:0];
  assign last_byte = (cnt_q == LAST_CNT);

endmodule

// File: rtl/debug_ctrl.sv
// UART-driven debug controller: loads program words, runs or steps the CPU and
// dumps the debug word set back over the UART.
module debug_ctrl
  import debug_pkg::*;
#(
  parameter int DATA_W     = 32,
  parameter int ADDR_W     = 11,
  parameter int DUMP_WORDS = 36
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic                          rx_done_tick,
  input  logic [7:0]                    rx_data,
  input  logic                          tx_done_tick,
  output logic                          tx_start,
  output logic [7:0]                    tx_data,
  input  logic                          halt,
  output logic [ADDR_W-1:0]             mem_addr,
  output logic [DATA_W-1:0]             mem_wdata,
  output logic                          mem_we,
  output logic                          mips_en,
  output logic [$clog2(DUMP_WORDS)-1:0] dump_sel,
  input  logic [DATA_W-1:0]             dump_data,
  output logic                          busy,
  output logic                          err
);

  localparam int BYTES = DATA_W / 8;
  localparam int CNT_W = (BYTES > 1) ? $clog2(BYTES) : 1;
  localparam int SEL_W = $clog2(DUMP_WORDS);
  localparam logic [CNT_W-1:0]  LAST_CNT = CNT_W'(BYTES - 1);
  localparam logic [SEL_W-1:0]  LAST_SEL = SEL_W'(DUMP_WORDS - 1);
  localparam logic [ADDR_W-1:0] MAX_ADDR = {ADDR_W{1'b1}};

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [CNT_W-1:0]  byte_cnt_q, byte_cnt_d;
  logic [SEL_W-1:0]  sel_q, sel_d;
  logic              err_q, err_d;
  logic              ser_load, ser_send, ser_shift, ser_last;

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    byte_cnt_d = byte_cnt_q;
    sel_d      = sel_q;
    err_d      = err_q;
    ser_load   = 1'b0;
    ser_send   = 1'b0;
    ser_shift  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_done_tick) begin
          case (rx_data)
            CMD_LOAD: begin
              state_d    = ST_LOAD_RX;
              addr_d     = '0;
              wdata_d    = '0;
              byte_cnt_d = '0;
              err_d      = 1'b0;
            end
            CMD_RUN:  state_d = ST_RUN;
            CMD_STEP: state_d = ST_STEP;
            CMD_DUMP: begin
              state_d = ST_DUMP_LD;
              sel_d   = '0;
            end
            default: ;
          endcase
        end
      end
      ST_LOAD_RX: begin
        // Each new byte enters at the top so the first byte ends up as the LSB.
        if (rx_done_tick) begin
          wdata_d = (wdata_q >> 8) | (DATA_W'(rx_data) << (DATA_W - 8));
          if (byte_cnt_q == LAST_CNT) begin
            byte_cnt_d = '0;
            state_d    = ST_LOAD_WR;
          end else begin
            byte_cnt_d = byte_cnt_q + 1'b1;
          end
        end
      end
      ST_LOAD_WR: begin
        if (wdata_q == '0) begin
          state_d = ST_IDLE;
          if (addr_q != MAX_ADDR) addr_d = addr_q + 1'b1;
        end else if (addr_q == MAX_ADDR) begin
          err_d   = 1'b1;
          state_d = ST_IDLE;
        end else begin
          addr_d  = addr_q + 1'b1;
          state_d = ST_LOAD_RX;
        end
      end
      ST_RUN: begin
        if (halt || (rx_done_tick && rx_data == CMD_ABORT)) state_d = ST_DUMP_LD;
      end
      ST_STEP: state_d = ST_DUMP_LD;
      ST_DUMP_LD: begin
        ser_load = 1'b1;
        state_d  = ST_DUMP_TX;
      end
      ST_DUMP_TX: begin
        ser_send = 1'b1;
        state_d  = ST_DUMP_WAIT;
      end
      ST_DUMP_WAIT: begin
        if (tx_done_tick) begin
          ser_shift = 1'b1;
          if (!ser_last) begin
            state_d = ST_DUMP_TX;
          end else if (sel_q == LAST_SEL) begin
            sel_d   = '0;
            state_d = ST_IDLE;
          end else begin
            sel_d   = sel_q + 1'b1;
            state_d = ST_DUMP_LD;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= ST_IDLE;
      addr_q     <= '0;
      wdata_q    <= '0;
      byte_cnt_q <= '0;
      sel_q      <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      byte_cnt_q <= byte_cnt_d;
      sel_q      <= sel_d;
      err_q      <= err_d;
    end
  end

  debug_word_ser #(.DATA_W(DATA_W)) u_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .word_in   (dump_data),
    .send      (ser_send),
    .shift     (ser_shift),
    .tx_start  (tx_start),
    .tx_data   (tx_data),
    .last_byte (ser_last)
  );

  assign mem_we    = (state_q == ST_LOAD_WR);
  assign mips_en   = (state_q == ST_RUN) || (state_q == ST_STEP);
  assign busy      = (state_q != ST_IDLE);
  assign mem_addr  = addr_q;
  assign mem_wdata = wdata_q;
  assign dump_sel  = sel_q;
  assign err       = err_q;

endmodule

// File: tb/tb_debug_ctrl.sv
// Directed self-checking bench for debug_ctrl (DATA_W=32, ADDR_W=2, DUMP_WORDS=2).
module tb_debug_ctrl;

  logic        clk;
  logic        reset;
  logic        rx_done_tick;
  logic [7:0]  rx_data;
  logic        tx_done_tick;
  logic        tx_start;
  logic [7:0]  tx_data;
  logic        halt;
  logic [1:0]  mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_we;
  logic        mips_en;
  logic [0:0]  dump_sel;
  logic [31:0] dump_data;
  logic        busy;
  logic        err;

  int n_checks;
  int n_fail;

  logic [1:0]  we_addr_q [$];
  logic [31:0] we_data_q [$];
  logic [7:0]  tx_q [$];
  int          mips_cycles;
  bit          overlap_seen;

  logic [7:0] exp_bytes [8] = '{8'hDD, 8'hCC, 8'hBB, 8'hAA, 8'h44, 8'h33, 8'h22, 8'h11};

  debug_ctrl #(.DATA_W(32), .ADDR_W(2), .DUMP_WORDS(2)) dut (
    .clk          (clk),
    .reset        (reset),
    .rx_done_tick (rx_done_tick),
    .rx_data      (rx_data),
    .tx_done_tick (tx_done_tick),
    .tx_start     (tx_start),
    .tx_data      (tx_data),
    .halt         (halt),
    .mem_addr     (mem_addr),
    .mem_wdata    (mem_wdata),
    .mem_we       (mem_we),
    .mips_en      (mips_en),
    .dump_sel     (dump_sel),
    .dump_data    (dump_data),
    .busy         (busy),
    .err          (err)
  );

  assign dump_data = (dump_sel == 1'b0) ? 32'hAABBCCDD : 32'h11223344;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Passive monitor: records writes, transmitted bytes and enabled CPU cycles.
  initial begin
    mips_cycles  = 0;
    overlap_seen = 1'b0;
  end
  always @(negedge clk) begin
    if (mem_we) begin
      we_addr_q.push_back(mem_addr);
      we_data_q.push_back(mem_wdata);
    end
    if (tx_start) tx_q.push_back(tx_data);
    if (mips_en) mips_cycles = mips_cycles + 1;
    if (mem_we && tx_start) overlap_seen = 1'b1;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    rx_data      = b;
    rx_done_tick = 1'b1;
    tick();
    rx_done_tick = 1'b0;
    for (int i = 0; i < gap; i++) tick();
  endtask

  task automatic wait_idle(input string name);
    int t;
    t = 0;
    while (busy !== 1'b0 && t < 200) begin
      tick();
      t++;
    end
    if (t >= 200) begin
      n_checks++;
      n_fail++;
      $display("[TB] FAIL %s_idle_timeout: busy=%b required 0", name, busy);
    end
  endtask

  // Acts as the UART transmitter for n bytes; optionally injects a stray
  // tx_done_tick during DUMP_TX and an rx command byte mid-dump.
  task automatic dump_respond(input string name, input int n, input bit stray, input bit poke);
    int t;
    for (int i = 0; i < n; i++) begin
      t = 0;
      while (tx_start !== 1'b1 && t < 50) begin
        tick();
        t++;
      end
      if (t >= 50) begin
        n_checks++;
        n_fail++;
        $display("[TB] FAIL %s_tx_timeout: byte %0d tx_start=%b required 1", name, i, tx_start);
        return;
      end
      if (stray && i == 0) tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
      tick();
      if (poke && i == 2) begin
        rx_data      = 8'h02;
        rx_done_tick = 1'b1;
      end
      tick();
      rx_done_tick = 1'b0;
      tx_done_tick = 1'b1;
      tick();
      tx_done_tick = 1'b0;
    end
  endtask

  task automatic check_dump_bytes(input string name, input int base);
    n_checks++;
    if (tx_q.size() - base !== 8) begin
      n_fail++;
      $display("[TB] FAIL %s_count: got %0d bytes required 8", name, tx_q.size() - base);
    end else begin
      for (int i = 0; i < 8; i++) begin
        n_checks++;
        if (tx_q[base+i] !== exp_bytes[i]) begin
          n_fail++;
          $display("[TB] FAIL %s_byte%0d: got %h required %h", name, i, tx_q[base+i], exp_bytes[i]);
        end
      end
    end
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    n_checks++; if (busy !== 1'b0)      begin n_fail++; $display("[TB] FAIL rst_busy: got %b required 0", busy); end
    n_checks++; if (tx_start !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_tx_start: got %b required 0", tx_start); end
    n_checks++; if (tx_data !== 8'h00)  begin n_fail++; $display("[TB] FAIL rst_tx_data: got %h required 00", tx_data); end
    n_checks++; if (mem_we !== 1'b0)    begin n_fail++; $display("[TB] FAIL rst_mem_we: got %b required 0", mem_we); end
    n_checks++; if (mem_addr !== 2'd0)  begin n_fail++; $display("[TB] FAIL rst_mem_addr: got %h required 0", mem_addr); end
    n_checks++; if (mem_wdata !== 32'h0) begin n_fail++; $display("[TB] FAIL rst_mem_wdata: got %h required 0", mem_wdata); end
    n_checks++; if (mips_en !== 1'b0)   begin n_fail++; $display("[TB] FAIL rst_mips_en: got %b required 0", mips_en); end
    n_checks++; if (dump_sel !== 1'b0)  begin n_fail++; $display("[TB] FAIL rst_dump_sel: got %h required 0", dump_sel); end
    n_checks++; if (err !== 1'b0)       begin n_fail++; $display("[TB] FAIL rst_err: got %b required 0", err); end
    reset = 1'b1;
    tick();
  endtask

  task automatic test_ignore_cmd();
    send_byte(8'h07, 2);
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ignore_busy: got %b required 0", busy); end
  endtask

  task automatic test_load();
    int base;
    base = we_addr_q.size();
    send_byte(8'h01, 2);
    send_byte(8'h78, 2); send_byte(8'h56, 2); send_byte(8'h34, 2); send_byte(8'h12, 2);
    send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    wait_idle("load");
    n_checks++;
    if (we_addr_q.size() - base !== 2) begin
      n_fail++; $display("[TB] FAIL load_we_count: got %0d required 2", we_addr_q.size() - base);
    end else begin
      n_checks++; if (we_addr_q[base] !== 2'd0)            begin n_fail++; $display("[TB] FAIL load_addr0: got %h required 0", we_addr_q[base]); end
      n_checks++; if (we_data_q[base] !== 32'h12345678)    begin n_fail++; $display("[TB] FAIL load_data0: got %h required 12345678", we_data_q[base]); end
      n_checks++; if (we_addr_q[base+1] !== 2'd1)          begin n_fail++; $display("[TB] FAIL load_addr1: got %h required 1", we_addr_q[base+1]); end
      n_checks++; if (we_data_q[base+1] !== 32'h00000000)  begin n_fail++; $display("[TB] FAIL load_data1: got %h required 0", we_data_q[base+1]); end
    end
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL load_err: got %b required 0", err); end
  endtask

  task automatic test_load_overflow();
    int base;
    base = we_addr_q.size();
    send_byte(8'h01, 2);
    for (int w = 1; w <= 4; w++) begin
      send_byte(8'(w), 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    end
    wait_idle("ovf");
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_err: got %b required 1", err); end
    n_checks++;
    if (we_addr_q.size() - base !== 4) begin
      n_fail++; $display("[TB] FAIL ovf_we_count: got %0d required 4", we_addr_q.size() - base);
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_checks++;
        if (we_addr_q[base+i] !== 2'(i) || we_data_q[base+i] !== 32'(i + 1)) begin
          n_fail++;
          $display("[TB] FAIL ovf_write%0d: got addr %h data %h required addr %h data %h",
                   i, we_addr_q[base+i], we_data_q[base+i], 2'(i), 32'(i + 1));
        end
      end
    end
    send_byte(8'h11, 2); send_byte(8'h22, 2); send_byte(8'h33, 2); send_byte(8'h44, 2);
    n_checks++; if (we_addr_q.size() - base !== 4) begin n_fail++; $display("[TB] FAIL ovf_no_fifth: got %0d writes required 4", we_addr_q.size() - base); end
    n_checks++; if (err !== 1'b1) begin n_fail++; $display("[TB] FAIL ovf_err_sticky: got %b required 1", err); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_busy: got %b required 0", busy); end
    send_byte(8'h01, 2);
    n_checks++; if (err !== 1'b0) begin n_fail++; $display("[TB] FAIL ovf_err_clear: got %b required 0", err); end
    send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2); send_byte(8'h00, 2);
    wait_idle("reload");
    n_checks++; if (we_addr_q.size() - base !== 5) begin n_fail++; $display("[TB] FAIL reload_we_count: got %0d required 5", we_addr_q.size() - base); end
  endtask

  task automatic test_step();
    int tx_base, mips_base;
    tx_base   = tx_q.size();
    mips_base = mips_cycles;
    halt = 1'b1;
    send_byte(8'h03, 0);
    dump_respond("step", 8, 1'b0, 1'b0);
    wait_idle("step");
    halt = 1'b0;
    n_checks++; if (mips_cycles - mips_base !== 1) begin n_fail++; $display("[TB] FAIL step_mips_cycles: got %0d required 1", mips_cycles - mips_base); end
    check_dump_bytes("step", tx_base);
    n_checks++; if (dump_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL step_dump_sel: got %h required 0", dump_sel); end
  endtask

  task automatic test_run_halt();
    int tx_base, mips_base;
    tx_base   = tx_q.size();
    mips_base = mips_cycles;
    send_byte(8'h02, 0);
    for (int i = 0; i < 9; i++) tick();
    halt = 1'b1;
    tick();
    n_checks++; if (mips_en !== 1'b0) begin n_fail++; $display("[TB] FAIL halt_mips_off: got %b required 0", mips_en); end
    dump_respond("halt", 8, 1'b0, 1'b0);
    wait_idle("halt");
    halt = 1'b0;
    n_checks++; if (mips_cycles - mips_base !== 10) begin n_fail++; $display("[TB] FAIL halt_mips_cycles: got %0d required 10", mips_cycles - mips_base); end
    check_dump_bytes("halt", tx_base);
  endtask

  task automatic test_run_abort();
    int tx_base, mips_base;
    tx_base   = tx_q.size();
    mips_base = mips_cycles;
    send_byte(8'h02, 0);
    for (int i = 0; i < 4; i++) tick();
    send_byte(8'h07, 0);
    for (int i = 0; i < 4; i++) tick();
    send_byte(8'h05, 0);
    n_checks++; if (mips_en !== 1'b0) begin n_fail++; $display("[TB] FAIL abort_mips_off: got %b required 0", mips_en); end
    dump_respond("abort", 8, 1'b0, 1'b0);
    wait_idle("abort");
    n_checks++; if (mips_cycles - mips_base !== 10) begin n_fail++; $display("[TB] FAIL abort_mips_cycles: got %0d required 10", mips_cycles - mips_base); end
    check_dump_bytes("abort", tx_base);
  endtask

  task automatic test_dump_cmd();
    int tx_base, mips_base;
    tx_base   = tx_q.size();
    mips_base = mips_cycles;
    send_byte(8'h04, 0);
    dump_respond("dump", 8, 1'b1, 1'b1);
    wait_idle("dump");
    n_checks++; if (mips_cycles - mips_base !== 0) begin n_fail++; $display("[TB] FAIL dump_mips_cycles: got %0d required 0", mips_cycles - mips_base); end
    check_dump_bytes("dump", tx_base);
  endtask

  task automatic test_reset_mid_dump();
    int tx_base, we_base, t;
    tx_base = tx_q.size();
    we_base = we_addr_q.size();
    send_byte(8'h04, 0);
    t = 0;
    while (tx_start !== 1'b1 && t < 50) begin
      tick();
      t++;
    end
    n_checks++; if (t >= 50) begin n_fail++; $display("[TB] FAIL rstdump_tx_timeout: tx_start=%b required 1", tx_start); end
    tick();
    reset = 1'b0;
    #1;
    n_checks++; if (busy !== 1'b0)     begin n_fail++; $display("[TB] FAIL rstdump_busy: got %b required 0", busy); end
    n_checks++; if (tx_data !== 8'h00) begin n_fail++; $display("[TB] FAIL rstdump_tx_data: got %h required 00", tx_data); end
    n_checks++; if (tx_start !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdump_tx_start: got %b required 0", tx_start); end
    n_checks++; if (dump_sel !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdump_dump_sel: got %h required 0", dump_sel); end
    n_checks++; if (mips_en !== 1'b0 || mem_we !== 1'b0 || err !== 1'b0)
      begin n_fail++; $display("[TB] FAIL rstdump_misc: got mips_en %b mem_we %b err %b required 0 0 0", mips_en, mem_we, err); end
    tick();
    tick();
    reset = 1'b1;
    tick();
    tx_done_tick = 1'b1;
    tick();
    tx_done_tick = 1'b0;
    for (int i = 0; i < 5; i++) tick();
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("[TB] FAIL rstdump_after_busy: got %b required 0", busy); end
    n_checks++; if (tx_q.size() - tx_base !== 1) begin n_fail++; $display("[TB] FAIL rstdump_tx_count: got %0d required 1", tx_q.size() - tx_base); end
    n_checks++; if (we_addr_q.size() - we_base !== 0) begin n_fail++; $display("[TB] FAIL rstdump_we_count: got %0d required 0", we_addr_q.size() - we_base); end
  endtask

  task automatic test_exclusive();
    n_checks++; if (overlap_seen !== 1'b0) begin n_fail++; $display("[TB] FAIL we_tx_overlap: got %b required 0", overlap_seen); end
  endtask

  initial begin
    n_checks     = 0;
    n_fail       = 0;
    reset        = 1'b0;
    rx_done_tick = 1'b0;
    rx_data      = 8'h00;
    tx_done_tick = 1'b0;
    halt         = 1'b0;
    #2;
    test_reset();
    test_ignore_cmd();
    test_load();
    test_load_overflow();
    test_step();
    test_run_halt();
    test_run_abort();
    test_dump_cmd();
    test_reset_mid_dump();
    test_exclusive();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
